// File: rtl/layer_stream_serializer.sv
// layer_stream_serializer
// Double-buffered parallel-to-serial converter between network layers. Accepts
// one packed frame of NUM_NEURONS words and streams it one word per transfer
// over a valid/ready handshake. A second frame may be captured into a pending
// buffer while the active one is sent; frames follow each other without a gap.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : packed frame, neuron k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   : frame offered on in_data
//   in_ready   : a frame can be accepted this cycle (pending buffer empty)
//   out_data   : current serial word
//   out_valid  : out_data valid
//   out_ready  : downstream accepts out_data
//   out_last   : current word is the last of its frame
//   out_index  : neuron number of the current word
//   busy       : an active or pending frame is held
//   overflow   : sticky, a frame was offered while in_ready was low
module layer_stream_serializer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_NEURONS = 30,
    parameter int unsigned IDX_WIDTH   = 5,
    parameter int unsigned MSB_FIRST   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic [IDX_WIDTH-1:0]              out_index,
    output logic                              busy,
    output logic                              overflow
);

    localparam int unsigned FRAME_W = NUM_NEURONS * DATA_WIDTH;
    localparam int unsigned CNT_W   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_NEURONS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t                 state_q;
    logic [FRAME_W-1:0]     active_q;
    logic [FRAME_W-1:0]     pending_q;
    logic                   pend_full_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [IDX_WIDTH-1:0]   out_index_q;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic                   in_ready_q;
    logic                   busy_q;
    logic                   overflow_q;

    logic accept;
    logic xfer;

    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;
    assign cnt_d  = cnt_q + CNT_W'(1);

    // Neuron position of the word sent at counter value c.
    function automatic int unsigned pos_of(input logic [CNT_W-1:0] c);
        if (MSB_FIRST != 0) begin
            return NUM_NEURONS - 1 - 32'(c);
        end
        return 32'(c);
    endfunction

    // Word of frame f sent at counter value c.
    function automatic logic [DATA_WIDTH-1:0] word_of(input logic [FRAME_W-1:0] f,
                                                      input logic [CNT_W-1:0]   c);
        return f[pos_of(c)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Control FSM, buffers and registered outputs. Output registers are loaded
    // with the word the new counter value selects, so they change only on a
    // transfer or a frame start and stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (in_valid && !in_ready_q) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        active_q    <= in_data;
                        cnt_q       <= '0;
                        state_q     <= ST_SEND;
                        out_valid_q <= 1'b1;
                        out_data_q  <= word_of(in_data, '0);
                        out_index_q <= IDX_WIDTH'(pos_of('0));
                        out_last_q  <= (CNT_LAST == '0);
                        busy_q      <= 1'b1;
                    end
                end

                ST_SEND: begin
                    if (xfer && !out_last_q) begin
                        cnt_q       <= cnt_d;
                        out_data_q  <= word_of(active_q, cnt_d);
                        out_index_q <= IDX_WIDTH'(pos_of(cnt_d));
                        out_last_q  <= (cnt_d == CNT_LAST);
                    end else if (xfer && pend_full_q) begin
                        // Promote the waiting frame with no bubble cycle.
                        active_q    <= pending_q;
                        pend_full_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cnt_q       <= '0;
                        out_data_q  <= word_of(pending_q, '0);
                        out_index_q <= IDX_WIDTH'(pos_of('0));
                        out_last_q  <= (CNT_LAST == '0);
                    end else if (xfer && accept) begin
                        // Frame arriving on the last transfer goes straight to active.
                        active_q    <= in_data;
                        cnt_q       <= '0;
                        out_data_q  <= word_of(in_data, '0);
                        out_index_q <= IDX_WIDTH'(pos_of('0));
                        out_last_q  <= (CNT_LAST == '0);
                    end else if (xfer) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                    end

                    // Capture into pending unless the frame was taken as active above.
                    if (accept && !(xfer && out_last_q)) begin
                        pending_q   <= in_data;
                        pend_full_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_index = out_index_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Testbench for layer_stream_serializer: two instances (LSB-first and
// MSB-first) share one stimulus stream and are compared every cycle against a
// frame-queue reference model.
module tb_layer_stream_serializer;

    localparam int unsigned DW = 8;
    localparam int unsigned NN = 4;
    localparam int unsigned IW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NN*DW-1:0]   in_data;
    logic               in_valid;
    logic               out_ready;

    logic               l_in_ready, l_out_valid, l_out_last, l_busy, l_overflow;
    logic [DW-1:0]      l_out_data;
    logic [IW-1:0]      l_out_index;
    logic               m_in_ready, m_out_valid, m_out_last, m_busy, m_overflow;
    logic [DW-1:0]      m_out_data;
    logic [IW-1:0]      m_out_index;

    always #5 clk = ~clk;

    layer_stream_serializer #(
        .DATA_WIDTH(DW), .NUM_NEURONS(NN), .IDX_WIDTH(IW), .MSB_FIRST(0)
    ) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_in_ready), .out_data(l_out_data), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_last(l_out_last), .out_index(l_out_index),
        .busy(l_busy), .overflow(l_overflow)
    );

    layer_stream_serializer #(
        .DATA_WIDTH(DW), .NUM_NEURONS(NN), .IDX_WIDTH(IW), .MSB_FIRST(1)
    ) dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_in_ready), .out_data(m_out_data), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_last(m_out_last), .out_index(m_out_index),
        .busy(m_busy), .overflow(m_overflow)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: frames held (active first), word position in the front frame.
    logic [NN*DW-1:0] fq[$];
    int               pos   = 0;
    bit               m_ovf = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic             exp_valid;
        logic             exp_ready;
        logic [NN*DW-1:0] f;
        int               kl;
        int               km;
        exp_valid = (fq.size() > 0);
        exp_ready = (fq.size() < 2);
        check_eq("lsb_valid",    32'(l_out_valid), 32'(exp_valid));
        check_eq("msb_valid",    32'(m_out_valid), 32'(exp_valid));
        check_eq("lsb_in_ready", 32'(l_in_ready),  32'(exp_ready));
        check_eq("msb_in_ready", 32'(m_in_ready),  32'(exp_ready));
        check_eq("lsb_busy",     32'(l_busy),      32'(exp_valid));
        check_eq("msb_busy",     32'(m_busy),      32'(exp_valid));
        check_eq("lsb_overflow", 32'(l_overflow),  32'(m_ovf));
        check_eq("msb_overflow", 32'(m_overflow),  32'(m_ovf));
        if (exp_valid) begin
            f  = fq[0];
            kl = pos;
            km = NN - 1 - pos;
            check_eq("lsb_data",  32'(l_out_data),  32'(f[kl*DW +: DW]));
            check_eq("lsb_index", 32'(l_out_index), 32'(kl));
            check_eq("lsb_last",  32'(l_out_last),  32'(pos == NN - 1));
            check_eq("msb_data",  32'(m_out_data),  32'(f[km*DW +: DW]));
            check_eq("msb_index", 32'(m_out_index), 32'(km));
            check_eq("msb_last",  32'(m_out_last),  32'(pos == NN - 1));
        end
    endtask

    task automatic model_update(input bit v, input logic [NN*DW-1:0] d, input bit r);
        bit rdy;
        rdy = (fq.size() < 2);
        if (fq.size() > 0 && r) begin
            pos++;
            if (pos == NN) begin
                void'(fq.pop_front());
                pos = 0;
            end
        end
        if (v && rdy) begin
            fq.push_back(d);
        end else if (v) begin
            m_ovf = 1'b1;
        end
    endtask

    // One clock: drive at negedge, check registered outputs, advance model.
    task automatic step(input bit v, input logic [NN*DW-1:0] d, input bit r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        check_outputs();
        model_update(v, d, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fq.delete();
        pos   = 0;
        m_ovf = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Single frame, full-rate drain.
        step(1'b1, 32'h44332211, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

        // Backpressure held on the second word.
        step(1'b1, 32'h44332211, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

        // Back-to-back frames, B offered during A's second word.
        step(1'b1, 32'h44332211, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h88776655, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

        // Overflow with both buffers full; C must never appear.
        step(1'b1, 32'h44332211, 1'b0);
        step(1'b1, 32'h88776655, 1'b0);
        step(1'b1, 32'hCCBBAA99, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0D0C0B0A, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

        // Reset after two words, then a fresh frame.
        step(1'b1, 32'h44332211, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        do_reset();
        step(1'b1, 32'hDDCCBBAA, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 99) < 35), 32'($urandom), ($urandom_range(0, 99) < 70));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/layer_stream_serializer.md
Name: layer_stream_serializer

Overview:
- Generic parallel-to-serial converter between neural-network layers.
- Captures one layer's packed neuron outputs and streams them one word per transfer, with a valid/ready handshake, into the next layer's serial input.
- Double-buffered, so the next layer result can be captured while the current one is still being sent.
- Replaces the hand-written per-layer serializers in the network top level and fixes word-count handling: exactly NUM_NEURONS words per frame.

Parameters:
- DATA_WIDTH, 16, width of one neuron output word.
- NUM_NEURONS, 30, words per frame; must be >= 1.
- IDX_WIDTH, 5, width of out_index; must be >= clog2(NUM_NEURONS), minimum 1.
- MSB_FIRST, 0, word order. 0 sends neuron 0 (bits DATA_WIDTH-1:0) first. 1 sends neuron NUM_NEURONS-1 first.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- in_data, input, NUM_NEURONS*DATA_WIDTH, packed layer outputs; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid, input, 1, frame present on in_data. The integrator drives this from bit 0 of the layer valid vector.
- in_ready, output, 1, block can accept a frame this cycle.
- out_data, output, DATA_WIDTH, current serial word.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data.
- out_last, output, 1, current word is the final word of its frame.
- out_index, output, IDX_WIDTH, neuron number of the current word.
- busy, output, 1, at least one frame is held (active or pending).
- overflow, output, 1, sticky flag: a frame was offered while in_ready was low.

Behaviour:
- Reset is synchronous on clk and active-high on rst.
  - Reset values: out_valid=0, out_last=0, out_index=0, out_data=0, busy=0, overflow=0, in_ready=1.
  - Both buffers are emptied and the state returns to IDLE.
  - A reset mid-frame abandons the frame; no partial words appear after reset.
- Storage:
  - Active buffer: the frame being sent, plus word counter cnt (0..NUM_NEURONS-1).
  - Pending buffer: holds one waiting frame.
- in_ready = !pending_full. It is derived from registered state only, with no combinational path from out_ready.
- Accept: in_valid && in_ready.
  - In IDLE, the frame loads into the active buffer.
  - In SEND, the frame loads into the pending buffer.
- Transfer: out_valid && out_ready.
- States:
  - IDLE: out_valid=0.
    - On accept, load active, cnt=0, go to SEND.
    - out_valid rises the next cycle, giving 1-cycle latency from accept to first word.
  - SEND: out_valid=1.
    - out_data is the word selected by cnt, which is reversed when MSB_FIRST=1.
    - out_index = cnt when MSB_FIRST=0, or NUM_NEURONS-1-cnt when MSB_FIRST=1.
    - out_last = (cnt == NUM_NEURONS-1).
    - On a transfer with cnt < NUM_NEURONS-1: cnt increments.
    - On a transfer with out_last=1:
      - If the pending buffer is full, pending moves to active, cnt=0, pending is cleared, and the state stays in SEND. There is no bubble cycle between frames.
      - Otherwise go to IDLE, with out_valid=0 the next cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable and cnt does not advance.
- Simultaneous events:
  - Accept and last-transfer in the same cycle, pending empty: the new frame goes to pending, then is promoted next cycle. Equivalently it becomes active directly; the result must be a gapless stream either way.
  - Accept in IDLE with the pending buffer empty is the normal path.
  - in_valid with in_ready=0: the frame is dropped, overflow is set to 1 and held until rst, and buffer contents are unchanged.
- NUM_NEURONS=1: every word has out_last=1 and out_index=0.
- busy = active_valid || pending_full, registered.

Test Plan:
- NUM_NEURONS=4, DATA_WIDTH=8, MSB_FIRST=0. Frame in_data=0x44332211, out_ready=1 -> out_data is 0x11,0x22,0x33,0x44 on consecutive cycles starting 1 cycle after accept; out_index 0..3; out_last only on 0x44; out_valid low afterwards; exactly 4 transfers.
- Same frame with MSB_FIRST=1 -> out_data 0x44,0x33,0x22,0x11 with out_index 3,2,1,0.
- Backpressure: out_ready low for 3 cycles while 0x22 is shown -> 0x22, index 1 held stable for those 3 cycles; the stream resumes with 0x33; no duplicate or lost words.
- Back-to-back frames:
  - Frame A=0x44332211, then frame B=0x88776655 offered during A's second word -> B accepted, in_ready drops; the output is 8 consecutive words 0x11..0x44, 0x55..0x88 with no gap.
  - out_last pulses after 0x44 and after 0x88.
- Overflow: with active and pending both full, offer frame C -> in_ready=0, C is never emitted, overflow=1 and stays 1 through later frames until rst.
- Reset mid-frame: assert rst after 2 words -> next cycle out_valid=0, busy=0, in_ready=1, overflow=0; a new frame is then sent from index 0.
